// File: rtl/vga_frame_fetch_sched.sv
// Frame-buffer read scheduler: splits each frame into fixed bursts gated on FIFO room.
// Optional double buffering is enabled with `define VGA_FETCH_DOUBLE_BUFFER_EN.
module vga_frame_fetch_sched #(
  parameter int unsigned HDISP      = 800,
  parameter int unsigned VDISP      = 480,
  parameter int unsigned BURST      = 16,
  parameter int unsigned FIFO_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                              pixel_clk,
  input  logic                              pixel_rst,
  input  logic                              frame_sync,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_free,
  output logic                              rd_req,
  output logic [31:0]                       rd_addr,
  output logic [7:0]                        rd_len,
  input  logic                              rd_ack,
  input  logic                              rd_done,
  output logic                              busy,
  output logic                              frame_done,
  output logic [7:0]                        overrun_cnt
`ifdef VGA_FETCH_DOUBLE_BUFFER_EN
  ,
  input  logic                              buf_swap,
  output logic                              cur_buf
`endif
);

  localparam int unsigned TOTAL = HDISP * VDISP;
  localparam int unsigned CW    = $clog2(TOTAL + 1);
  localparam int unsigned FW    = $clog2(FIFO_DEPTH + 1);

  if (TOTAL % BURST != 0) begin : g_bad_burst
    $error("HDISP*VDISP must be a multiple of BURST");
  end
  if (FIFO_DEPTH < BURST) begin : g_bad_depth
    $error("FIFO_DEPTH must be at least BURST");
  end

  typedef enum logic [1:0] {IDLE, CHECK, REQ, WAIT} state_t;

  state_t        state;
  logic [CW-1:0] pix_cnt;
  logic          restart_pend;

  logic          done_evt;
  logic [CW-1:0] pix_next;
  logic          last_burst;
  logic          final_done;
  logic          ovr_evt;
  logic [CW-1:0] cnt_eff;
  logic [31:0]   frame_base;

  // A same-cycle ack+done is handled exactly like a done seen in WAIT.
  assign done_evt   = (state == WAIT && rd_done) || (state == REQ && rd_ack && rd_done);
  assign pix_next   = pix_cnt + CW'(BURST);
  assign last_burst = (pix_next == CW'(TOTAL));
  assign final_done = done_evt && last_burst && !restart_pend;
  assign ovr_evt    = frame_sync && (state != IDLE) && !final_done;
  assign cnt_eff    = frame_sync ? '0 : pix_cnt;

`ifdef VGA_FETCH_DOUBLE_BUFFER_EN
  logic swap_pend;
  logic frame_start;

  assign frame_start = frame_sync && (state == IDLE || final_done);
  assign frame_base  = cur_buf ? (BASE_ADDR + 32'(4 * TOTAL)) : BASE_ADDR;

  // Buffer selection only changes at a frame boundary.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      cur_buf   <= 1'b0;
      swap_pend <= 1'b0;
    end else if (frame_start && (swap_pend || buf_swap)) begin
      cur_buf   <= ~cur_buf;
      swap_pend <= 1'b0;
    end else if (buf_swap) begin
      swap_pend <= 1'b1;
    end
  end
`else
  assign frame_base = BASE_ADDR;
`endif

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state        <= IDLE;
      pix_cnt      <= '0;
      restart_pend <= 1'b0;
      rd_req       <= 1'b0;
      rd_addr      <= BASE_ADDR;
      rd_len       <= 8'(BURST);
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      overrun_cnt  <= 8'd0;
    end else begin
      frame_done <= 1'b0;
      rd_len     <= 8'(BURST);
      if (ovr_evt && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (frame_sync) begin
            pix_cnt <= '0;
            state   <= CHECK;
            busy    <= 1'b1;
          end
        end
        CHECK: begin
          pix_cnt <= cnt_eff;
          if (fifo_free >= FW'(BURST)) begin
            rd_req  <= 1'b1;
            rd_addr <= frame_base + (32'(cnt_eff) << 2);
            state   <= REQ;
          end
        end
        REQ, WAIT: begin
          if (state == REQ && rd_ack) begin
            rd_req <= 1'b0;
            state  <= WAIT;
          end
          if (done_evt) begin
            restart_pend <= 1'b0;
            if (restart_pend || (frame_sync && !last_burst)) begin
              pix_cnt <= '0;
              state   <= CHECK;
            end else if (last_burst) begin
              // Final burst: a coincident frame_sync starts the next frame directly.
              frame_done <= 1'b1;
              pix_cnt    <= frame_sync ? '0 : pix_next;
              state      <= frame_sync ? CHECK : IDLE;
              busy       <= frame_sync;
            end else begin
              pix_cnt <= pix_next;
              state   <= CHECK;
            end
          end else if (frame_sync) begin
            restart_pend <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_fetch_sched.sv
// Scoreboard bench for vga_frame_fetch_sched (16x4 frame, 8-pixel bursts).
// Builds with or without VGA_FETCH_DOUBLE_BUFFER_EN.
module tb_vga_frame_fetch_sched;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst = 1'b1;
  logic        frame_sync = 1'b0;
  logic [8:0]  fifo_free = 9'd256;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [7:0]  rd_len;
  logic        rd_ack = 1'b0;
  logic        rd_done = 1'b0;
  logic        busy;
  logic        frame_done;
  logic [7:0]  overrun_cnt;
`ifdef VGA_FETCH_DOUBLE_BUFFER_EN
  logic        buf_swap = 1'b0;
  logic        cur_buf;
`endif

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  logic [31:0] exp_q[$];

  vga_frame_fetch_sched #(
    .HDISP(16), .VDISP(4), .BURST(8), .FIFO_DEPTH(256), .BASE_ADDR(32'h0)
  ) dut (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .frame_sync(frame_sync),
    .fifo_free(fifo_free), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_ack(rd_ack), .rd_done(rd_done), .busy(busy), .frame_done(frame_done),
    .overrun_cnt(overrun_cnt)
`ifdef VGA_FETCH_DOUBLE_BUFFER_EN
    , .buf_swap(buf_swap), .cur_buf(cur_buf)
`endif
  );

  always #5 pixel_clk = ~pixel_clk;

  always @(posedge pixel_clk) if (frame_done) fd_cnt <= fd_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge pixel_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(base + 32'(32 * k));
  endtask

  task automatic sync_pulse();
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
  endtask

  // mode: 0 normal, 1 ack+done together, 2 frame_sync during WAIT, 3 frame_sync with done
  task automatic serve(input int ack_dly, input int mode, input int exp_lat);
    int lat;
    logic [31:0] e;
    lat = 0;
    while (!rd_req && lat < 40) begin
      step();
      lat++;
    end
    check("req_seen", 32'(rd_req), 32'd1);
    if (exp_lat >= 0) check("req_lat", 32'(lat), 32'(exp_lat));
    check("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check("rd_addr", rd_addr, e);
    check("rd_len", 32'(rd_len), 32'd8);
    repeat (ack_dly) begin
      step();
      check("req_hold", 32'(rd_req), 32'd1);
      check("addr_hold", rd_addr, e);
    end
    rd_ack  = 1'b1;
    rd_done = (mode == 1);
    step();
    rd_ack  = 1'b0;
    rd_done = 1'b0;
    check("req_drop", 32'(rd_req), 32'd0);
    if (mode != 1) begin
      if (mode == 2) begin
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        repeat (2) step();
      end else begin
        repeat (3) step();
      end
      rd_done    = 1'b1;
      frame_sync = (mode == 3);
      step();
      rd_done    = 1'b0;
      frame_sync = 1'b0;
    end
  endtask

  initial begin
    repeat (3) step();
    pixel_rst = 1'b0;
    step();
    check("rst_req", 32'(rd_req), 32'd0);
    check("rst_addr", rd_addr, 32'h0);
    check("rst_len", 32'(rd_len), 32'd8);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    check("rst_ovr", 32'(overrun_cnt), 32'd0);

    // Plain frame
    push_frame(32'h0, 8);
    sync_pulse();
    for (int k = 0; k < 8; k++) serve(0, 0, 1);
    check("fd_pulse", 32'(frame_done), 32'd1);
    check("busy_fall", 32'(busy), 32'd0);
    check("ovr_none", 32'(overrun_cnt), 32'd0);
    step();
    check("fd_once", 32'(fd_cnt), 32'd1);
    check("fd_clear", 32'(frame_done), 32'd0);

    // FIFO room gating, withheld ack, same-cycle ack+done
    fifo_free = 9'd7;
    push_frame(32'h0, 8);
    sync_pulse();
    repeat (10) begin
      step();
      check("no_req_low_room", 32'(rd_req), 32'd0);
    end
    check("busy_check", 32'(busy), 32'd1);
    fifo_free = 9'd8;
    serve(10, 0, 1);
    serve(0, 1, 1);
    for (int k = 0; k < 6; k++) serve(0, 0, 1);
    check("fd_pulse2", 32'(frame_done), 32'd1);
    fifo_free = 9'd256;
    step();
    check("fd_cnt2", 32'(fd_cnt), 32'd2);

    // Overrun in WAIT of third burst, then final done coincident with frame_sync
    push_frame(32'h0, 3);
    push_frame(32'h0, 8);
    push_frame(32'h0, 8);
    sync_pulse();
    serve(0, 0, 1);
    serve(0, 0, 1);
    serve(0, 2, 1);
    check("ovr_one", 32'(overrun_cnt), 32'd1);
    for (int k = 0; k < 7; k++) serve(0, 0, 1);
    serve(0, 3, 1);
    check("fd_sync_pulse", 32'(frame_done), 32'd1);
    check("busy_restart", 32'(busy), 32'd1);
    check("ovr_not_final", 32'(overrun_cnt), 32'd1);
    for (int k = 0; k < 8; k++) serve(0, 0, 1);
    step();
    check("fd_cnt4", 32'(fd_cnt), 32'd4);
    check("ovr_still_one", 32'(overrun_cnt), 32'd1);

    // Saturation: hold frame_sync while stuck in CHECK
    fifo_free  = 9'd0;
    frame_sync = 1'b1;
    repeat (301) step();
    frame_sync = 1'b0;
    step();
    check("ovr_sat", 32'(overrun_cnt), 32'd255);

    // Async reset while rd_req is high
    fifo_free = 9'd256;
    step();
    check("req_before_rst", 32'(rd_req), 32'd1);
    check("addr_before_rst", rd_addr, 32'h0);
    #2 pixel_rst = 1'b1;
    #1;
    check("async_rst_req", 32'(rd_req), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_ovr", 32'(overrun_cnt), 32'd0);
    step();
    pixel_rst = 1'b0;
    rd_ack    = 1'b1;
    rd_done   = 1'b1;
    step();
    rd_ack    = 1'b0;
    rd_done   = 1'b0;
    step();
    check("stale_done_busy", 32'(busy), 32'd0);
    check("stale_done_req", 32'(rd_req), 32'd0);
    check("stale_done_fd", 32'(fd_cnt), 32'd4);
    push_frame(32'h0, 8);
    sync_pulse();
    for (int k = 0; k < 8; k++) serve(0, 0, 1);
    step();
    check("fd_cnt5", 32'(fd_cnt), 32'd5);

`ifdef VGA_FETCH_DOUBLE_BUFFER_EN
    // Swap request mid-frame only takes effect at the next frame start
    push_frame(32'h0, 8);
    sync_pulse();
    for (int k = 0; k < 3; k++) serve(0, 0, 1);
    buf_swap = 1'b1;
    step();
    buf_swap = 1'b0;
    serve(0, 0, -1);
    for (int k = 0; k < 4; k++) serve(0, 0, 1);
    check("cur_buf_hold", 32'(cur_buf), 32'd0);
    step();
    check("fd_cnt6", 32'(fd_cnt), 32'd6);
    push_frame(32'h100, 8);
    sync_pulse();
    check("cur_buf_swap", 32'(cur_buf), 32'd1);
    for (int k = 0; k < 8; k++) serve(0, 0, 1);
`endif

    repeat (2) step();
    check("q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
